// File: rtl/mac_controller.sv
// Sequencing FSM for the 16x16 multiply-accumulate datapath.
// All strobes are Moore decodes of the state register; only ld_a/ld_b also depend on in_valid.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; length captured on accepted start
// CLEAR  | clear accumulator (and operands/product/counter if CLR_OPS)
// LOADN  | load datapath counter from N_o
// CHECK  | inspect eqz: finished or fetch the next pair
// FETCH  | in_ready high; wait for an operand transfer
// MUL    | load product register
// ACC    | accumulate product and decrement counter
// DONE   | one-cycle done pulse, back to IDLE
module mac_controller #(
  parameter int N_W     = 16,
  parameter bit CLR_OPS = 1'b1
) (
  input  logic           clk,
  input  logic           clr_n,
  input  logic           start,
  input  logic           abort,
  input  logic [N_W-1:0] n_len,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           eqz,
  output logic [N_W-1:0] N_o,
  output logic           ld_a,
  output logic           ld_b,
  output logic           ld_p,
  output logic           ld_acc,
  output logic           ld_N,
  output logic           dec_N,
  output logic           clr,
  output logic           clr_acc,
  output logic           busy,
  output logic           done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOADN, S_CHECK, S_FETCH, S_MUL, S_ACC, S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [N_W-1:0] n_q, n_d;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    in_ready = 1'b0;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    ld_p     = 1'b0;
    ld_acc   = 1'b0;
    ld_N     = 1'b0;
    dec_N    = 1'b0;
    clr      = 1'b0;
    clr_acc  = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = n_len;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        clr_acc = 1'b1;
        clr     = CLR_OPS;
        state_d = S_LOADN;
      end
      S_LOADN: begin
        ld_N    = 1'b1;
        state_d = S_CHECK;
      end
      S_CHECK: state_d = eqz ? S_DONE : S_FETCH;
      S_FETCH: begin
        in_ready = 1'b1;
        ld_a     = in_valid;
        ld_b     = in_valid;
        if (in_valid) state_d = S_MUL;
      end
      S_MUL: begin
        ld_p    = 1'b1;
        state_d = S_ACC;
      end
      S_ACC: begin
        ld_acc  = 1'b1;
        dec_N   = 1'b1;
        state_d = S_CHECK;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // abort wins over every transition; a same-cycle FETCH transfer still loads A/B
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  assign busy = (state_q != S_IDLE);
  assign N_o  = n_q;

endmodule

// File: tb/tb_mac_controller.sv
// Directed bench for mac_controller with a behavioural datapath model (A, B, P, acc, counter).
module tb_mac_controller;

  logic        clk = 1'b0;
  logic        clr_n, start, abort, in_valid, eqz;
  logic [15:0] n_len, a_in, b_in;
  logic        in_ready, ld_a, ld_b, ld_p, ld_acc, ld_N, dec_N, clr, clr_acc, busy, done;
  logic [15:0] N_o;

  int n_asserts = 0;
  int n_fail    = 0;

  mac_controller #(.N_W(16), .CLR_OPS(1'b1)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .abort(abort), .n_len(n_len),
    .in_valid(in_valid), .in_ready(in_ready), .eqz(eqz), .N_o(N_o),
    .ld_a(ld_a), .ld_b(ld_b), .ld_p(ld_p), .ld_acc(ld_acc), .ld_N(ld_N),
    .dec_N(dec_N), .clr(clr), .clr_acc(clr_acc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [15:0] dp_a = '0, dp_b = '0, dp_cnt = '0;
  logic [31:0] dp_p = '0;
  logic [63:0] dp_acc = '0;

  always @(posedge clk) begin
    if (clr) begin
      dp_a <= '0; dp_b <= '0; dp_p <= '0; dp_cnt <= '0;
    end else begin
      if (ld_a) dp_a <= a_in;
      if (ld_b) dp_b <= b_in;
      if (ld_p) dp_p <= 32'(dp_a) * 32'(dp_b);
      if (ld_N) dp_cnt <= N_o;
      else if (dec_N) dp_cnt <= dp_cnt - 16'd1;
    end
    if (clr_acc) dp_acc <= '0;
    else if (ld_acc) dp_acc <= dp_acc + 64'(dp_p);
  end
  assign eqz = (dp_cnt == 16'd0);

  int done_cnt = 0, dec_cnt = 0, rdy_cnt = 0;
  always @(posedge clk) begin
    if (done)     done_cnt <= done_cnt + 1;
    if (dec_N)    dec_cnt  <= dec_cnt + 1;
    if (in_ready) rdy_cnt  <= rdy_cnt + 1;
  end

  logic [15:0] opa [8];
  logic [15:0] opb [8];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_asserts++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Latency = number of edges from the start-sample edge up to the edge that ends the done cycle.
  task automatic run_job(input int len, input int stall, input int abort_mul,
                         input bit restart, input bit rst_acc,
                         output int lat, output bit hit_done);
    int edges, idx, scnt, muls;
    bit xfer;
    edges = 0; idx = 0; scnt = 0; muls = 0; lat = -1; hit_done = 1'b0;
    n_len = 16'(len);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_len = 16'h00AA;
    for (int c = 0; c < 400; c++) begin
      if (done) begin
        lat = edges + 1;
        hit_done = 1'b1;
        in_valid = 1'b0;
        if (restart) begin start = 1'b1; n_len = 16'd7; end
        @(posedge clk); #1;
        start = 1'b0;
        return;
      end
      if (ld_p) muls++;
      if (abort_mul != 0 && ld_p && muls == abort_mul) begin
        abort = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        return;
      end
      if (rst_acc && ld_acc) begin
        clr_n = 1'b0;
        #1;
        check("rst_busy",    64'(busy),     64'd0);
        check("rst_ld_acc",  64'(ld_acc),   64'd0);
        check("rst_dec_N",   64'(dec_N),    64'd0);
        check("rst_N_o",     64'(N_o),      64'd0);
        check("rst_inready", 64'(in_ready), 64'd0);
        check("rst_done",    64'(done),     64'd0);
        clr_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        return;
      end
      if (in_ready) begin
        if (scnt < stall) begin
          in_valid = 1'b0;
          scnt++;
        end else begin
          in_valid = 1'b1;
          a_in = opa[idx];
          b_in = opb[idx];
        end
      end else begin
        in_valid = 1'b0;
      end
      start = restart && in_ready;
      if (start) n_len = 16'd7;
      xfer = in_ready && in_valid;
      @(posedge clk);
      edges++;
      if (xfer) begin idx++; scnt = 0; end
      #1;
    end
    check("job_timeout", 64'(done), 64'd1);
  endtask

  int lat, d0, k0, r0;
  bit hit;

  initial begin
    clr_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    n_len = '0; a_in = '0; b_in = '0;
    for (int i = 0; i < 8; i++) begin opa[i] = '0; opb[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy",     64'(busy),     64'd0);
    check("reset_done",     64'(done),     64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    check("reset_N_o",      64'(N_o),      64'd0);
    check("reset_ld_N",     64'(ld_N),     64'd0);
    check("reset_clr_acc",  64'(clr_acc),  64'd0);
    clr_n = 1'b1;
    @(posedge clk); #1;
    check("idle_no_start", 64'(busy), 64'd0);

    // T1: 2*3 + 4*5 + 6*7 = 68, latency 4 + 4*3
    opa[0] = 16'd2; opb[0] = 16'd3;
    opa[1] = 16'd4; opb[1] = 16'd5;
    opa[2] = 16'd6; opb[2] = 16'd7;
    d0 = done_cnt; k0 = dec_cnt;
    run_job(3, 0, 0, 1'b0, 1'b0, lat, hit);
    check("t1_done_seen", 64'(hit), 64'd1);
    check("t1_latency",   64'(lat), 64'd16);
    check("t1_acc",       dp_acc,   64'd68);
    check("t1_dec_count", 64'(dec_cnt - k0),  64'd3);
    check("t1_done_once", 64'(done_cnt - d0), 64'd1);
    check("t1_N_o",       64'(N_o), 64'd3);
    check("t1_idle",      64'(busy), 64'd0);

    // T2: zero length, no handshake
    r0 = rdy_cnt;
    run_job(0, 0, 0, 1'b0, 1'b0, lat, hit);
    check("t2_latency",    64'(lat), 64'd4);
    check("t2_acc",        dp_acc,   64'd0);
    check("t2_no_ready",   64'(rdy_cnt - r0), 64'd0);

    // T3: 0xFFFF^2 = 0xFFFE0001, twice = 0x1_FFFC_0002, 5 stall cycles per pair
    opa[0] = 16'hFFFF; opb[0] = 16'hFFFF;
    opa[1] = 16'hFFFF; opb[1] = 16'hFFFF;
    run_job(2, 5, 0, 1'b0, 1'b0, lat, hit);
    check("t3_latency", 64'(lat), 64'd22);
    check("t3_acc",     dp_acc,   64'h1_FFFC_0002);

    // T4: abort during the second MUL, then a clean 3*3 job
    for (int i = 0; i < 4; i++) begin opa[i] = 16'(i + 1); opb[i] = 16'd2; end
    d0 = done_cnt;
    run_job(4, 0, 2, 1'b0, 1'b0, lat, hit);
    check("t4_no_done_hit", 64'(hit),      64'd0);
    check("t4_abort_idle",  64'(busy),     64'd0);
    check("t4_abort_rdy",   64'(in_ready), 64'd0);
    repeat (6) @(posedge clk);
    #1;
    check("t4_no_done",     64'(done_cnt - d0), 64'd0);
    check("t4_stay_idle",   64'(busy),     64'd0);
    opa[0] = 16'd3; opb[0] = 16'd3;
    run_job(1, 0, 0, 1'b0, 1'b0, lat, hit);
    check("t4_acc_after",   dp_acc,   64'd9);
    check("t4_latency",     64'(lat), 64'd8);

    // T5: start re-asserted in FETCH and DONE is ignored
    opa[0] = 16'd1; opb[0] = 16'd1;
    opa[1] = 16'd2; opb[1] = 16'd1;
    d0 = done_cnt;
    run_job(2, 0, 0, 1'b1, 1'b0, lat, hit);
    check("t5_latency", 64'(lat), 64'd12);
    check("t5_acc",     dp_acc,   64'd3);
    check("t5_N_o",     64'(N_o), 64'd2);
    repeat (4) @(posedge clk);
    #1;
    check("t5_idle",      64'(busy),           64'd0);
    check("t5_done_once", 64'(done_cnt - d0),  64'd1);
    check("t5_N_o_kept",  64'(N_o),            64'd2);

    // T6: async reset during ACC, then the FSM waits for start
    opa[0] = 16'd9; opb[0] = 16'd9;
    opa[1] = 16'd9; opb[1] = 16'd9;
    opa[2] = 16'd9; opb[2] = 16'd9;
    run_job(3, 0, 0, 1'b0, 1'b1, lat, hit);
    repeat (5) @(posedge clk);
    #1;
    check("t6_stay_idle", 64'(busy), 64'd0);
    check("t6_N_o",       64'(N_o),  64'd0);
    opa[0] = 16'd5; opb[0] = 16'd5;
    run_job(1, 0, 0, 1'b0, 1'b0, lat, hit);
    check("t6_acc_after", dp_acc, 64'd25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
